// File: rtl/onewire_master_if.sv
// onewire_master_if: Avalon-MM register port plus 1-wire pad signals of the 1-wire master
interface onewire_master_if #(
  parameter int OWN = 2
);
  logic           avalon_read;
  logic           avalon_write;
  logic [31:0]    avalon_writedata;
  logic [31:0]    avalon_readdata;
  logic           avalon_interrupt;
  logic [OWN-1:0] onewire_o;
  logic [OWN-1:0] onewire_oe;
  logic [OWN-1:0] onewire_i;
  modport slave (
    input  avalon_read, avalon_write, avalon_writedata, onewire_i,
    output avalon_readdata, avalon_interrupt, onewire_o, onewire_oe
  );
  modport master (
    output avalon_read, avalon_write, avalon_writedata, onewire_i,
    input  avalon_readdata, avalon_interrupt, onewire_o, onewire_oe
  );
endinterface

// File: rtl/onewire_master.sv
// onewire_master: Avalon-MM 1-wire master issuing one reset/presence or bit timeslot per command
module onewire_master #(
  parameter int CDR = 24,
  parameter int OWN = 2
) (
  input logic             clk,
  input logic             rst,
  onewire_master_if.slave bus
);
  localparam logic [1:0] IDLE = 2'd0, LOW = 2'd1, HIGH = 2'd2;
  localparam int CW = CDR > 1 ? $clog2(CDR) : 1;
  logic [1:0]          state;
  logic [CW-1:0]       cnt;
  logic [9:0]          t, tn, t_low, t_smp, t_end;
  logic [1:0][OWN-1:0] sync;
  logic [3:0]          sel, sel_w;
  logic [OWN-1:0]      mask;
  logic [31:0]         wd;
  logic                dat, cyc_rst, ien, pnd, busy, tick, start, unused_wd;
  assign wd = bus.avalon_writedata;
  assign unused_wd = ^{wd[31:12], wd[7:4]};
  assign busy = state != IDLE;
  assign tick = cnt == CW'(CDR - 1);
  assign tn = t + 10'd1;
  // dat holds the bit being written until the sample point overwrites it in HIGH
  assign t_low = cyc_rst ? 10'd480 : dat ? 10'd6 : 10'd60;
  assign t_smp = cyc_rst ? 10'd550 : 10'd15;
  assign t_end = cyc_rst ? 10'd960 : 10'd70;
  assign sel_w = {1'b0, wd[11:8]} < 5'(OWN) ? wd[11:8] : 4'd0;
  assign mask = OWN'(1) << sel;
  assign start = !busy && bus.avalon_write && wd[3];
  assign bus.onewire_o = '0;
  assign bus.onewire_oe = state == LOW ? mask : '0;
  assign bus.avalon_readdata = {20'd0, sel, 3'd0, pnd, busy, ien, cyc_rst, dat};
  assign bus.avalon_interrupt = pnd & ien;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      t       <= '0;
      sync    <= '0;
      sel     <= '0;
      dat     <= 1'b0;
      cyc_rst <= 1'b0;
      ien     <= 1'b0;
      pnd     <= 1'b0;
    end else begin
      sync <= {sync[0], bus.onewire_i};
      cnt  <= start || tick ? '0 : cnt + 1'b1;
      t    <= start ? '0 : tick ? tn : t;
      if (bus.avalon_read) pnd <= 1'b0;
      if (!busy && bus.avalon_write) begin
        ien <= wd[2];
        sel <= sel_w;
      end
      if (start) begin
        state   <= LOW;
        dat     <= wd[0];
        cyc_rst <= wd[1];
      end
      if (tick && state == LOW && tn == t_low) state <= HIGH;
      if (tick && state == HIGH && tn == t_smp) dat <= |(sync[1] & mask);
      if (tick && state == HIGH && tn == t_end) begin
        state <= IDLE;
        pnd   <= 1'b1;
      end
    end
endmodule

// File: tb/tb_onewire_master.sv
// tb_onewire_master: table-driven timeslot checks with pull-up bus and slave pull-down model
module tb_onewire_master;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [1:0] pull = 2'b00;
  int checks = 0;
  int failures = 0;
  onewire_master_if #(.OWN(2)) bus ();
  onewire_master #(.CDR(2), .OWN(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  assign bus.onewire_i = ~(bus.onewire_oe | pull);
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] wd;
    logic [1:0]  mask;
    int          pa, pb;
    logic [1:0]  pl;
    int          ew_at, oe_n, busy_n, irq_at;
    logic [31:0] rd;
  } vec_t;
  vec_t v [5];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic wr(input logic [31:0] d);
    @(negedge clk);
    bus.avalon_write = 1'b1;
    bus.avalon_writedata = d;
    @(posedge clk);
    #1 bus.avalon_write = 1'b0;
  endtask
  task automatic rd_clear();
    @(negedge clk);
    bus.avalon_read = 1'b1;
    @(posedge clk);
    #1 bus.avalon_read = 1'b0;
  endtask
  initial begin
    int oe_n, busy_n, irq_at, bad, j;
    bus.avalon_read = 1'b0;
    bus.avalon_write = 1'b0;
    bus.avalon_writedata = '0;
    v[0] = '{32'h008, 2'b01, 0, 0, 2'b00, -1, 120, 140, -1, 32'h010};
    v[1] = '{32'h009, 2'b01, 8, 60, 2'b01, -1, 12, 140, -1, 32'h010};
    v[2] = '{32'h10A, 2'b10, 1000, 1240, 2'b10, -1, 960, 1920, -1, 32'h112};
    v[3] = '{32'h00D, 2'b01, 0, 0, 2'b00, 50, 12, 140, 140, 32'h015};
    v[4] = '{32'h309, 2'b01, 0, 0, 2'b00, -1, 12, 140, -1, 32'h011};
    #1 rst = 1'b1;
    #1;
    chk("rst_oe", {30'd0, bus.onewire_oe}, 32'h0);
    chk("rst_o", {30'd0, bus.onewire_o}, 32'h0);
    chk("rst_irq", {31'd0, bus.avalon_interrupt}, 32'h0);
    chk("rst_rd", bus.avalon_readdata, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_rd", bus.avalon_readdata, 32'h0);
    for (int i = 0; i < 5; i++) begin
      oe_n = 0; busy_n = 0; irq_at = -1; bad = 0;
      wr(v[i].wd);
      for (j = 0; j < 2100; j++) begin
        @(negedge clk);
        pull = (j >= v[i].pa && j < v[i].pb) ? v[i].pl : 2'b00;
        bus.avalon_write = (j == v[i].ew_at);
        bus.avalon_writedata = 32'h008;
        if (bus.onewire_oe != 2'b00) oe_n++;
        if ((bus.onewire_oe != 2'b00 && bus.onewire_oe != v[i].mask) || bus.onewire_o != 2'b00) bad++;
        if (bus.avalon_readdata[3]) busy_n++;
        if (bus.avalon_interrupt && irq_at < 0) irq_at = j;
        if (!bus.avalon_readdata[3]) break;
      end
      pull = 2'b00;
      bus.avalon_write = 1'b0;
      chk($sformatf("v%0d_oe_len", i), oe_n, v[i].oe_n);
      chk($sformatf("v%0d_busy_len", i), busy_n, v[i].busy_n);
      chk($sformatf("v%0d_irq_at", i), irq_at, v[i].irq_at);
      chk($sformatf("v%0d_line_bad", i), bad, 0);
      chk($sformatf("v%0d_rd", i), bus.avalon_readdata, v[i].rd);
      rd_clear();
      chk($sformatf("v%0d_rd_clr", i), bus.avalon_readdata, v[i].rd & ~32'h10);
      chk($sformatf("v%0d_irq_clr", i), {31'd0, bus.avalon_interrupt}, 32'h0);
    end
    // completion and read on the same edge: pnd stays set
    wr(32'h009);
    repeat (140) @(negedge clk);
    chk("pre_done_busy", {31'd0, bus.avalon_readdata[3]}, 32'h1);
    bus.avalon_read = 1'b1;
    @(posedge clk);
    #1 bus.avalon_read = 1'b0;
    chk("set_wins_rd", bus.avalon_readdata, 32'h011);
    // back-to-back start in the first cycle after busy falls
    wr(32'h008);
    chk("b2b_busy", {31'd0, bus.avalon_readdata[3]}, 32'h1);
    chk("b2b_oe", {30'd0, bus.onewire_oe}, 32'h1);
    for (int k = 0; k < 400 && bus.avalon_readdata[3]; k++) @(negedge clk);
    chk("b2b_done", bus.avalon_readdata, 32'h010);
    rd_clear();
    // asynchronous reset in the middle of the low phase
    wr(32'h00C);
    repeat (30) @(negedge clk);
    chk("mid_oe", {30'd0, bus.onewire_oe}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async_oe", {30'd0, bus.onewire_oe}, 32'h0);
    chk("async_rd", bus.avalon_readdata, 32'h0);
    #3 rst = 1'b0;
    oe_n = 0; irq_at = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.onewire_oe != 2'b00) oe_n++;
      if (bus.avalon_interrupt && irq_at < 0) irq_at = k;
    end
    chk("after_rst_oe", oe_n, 0);
    chk("after_rst_irq", irq_at, -1);
    chk("after_rst_rd", bus.avalon_readdata, 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
